// File: rtl/proc_pkg.sv
// -----------------------------------------------------------------------------
// proc_pkg
// Shared definitions for the segmented processor pipeline.
//  - Bit positions inside the 10-bit decoder control word.
//  - ALU-op encodings carried in control bits [1:0].
//  - Primary opcode values recognised by the main decoder.
// No ports; imported by the pipeline stage modules.
// -----------------------------------------------------------------------------
package proc_pkg;

  // Control word bit map
  localparam int CTRL_JUMP       = 9;
  localparam int CTRL_REG_DST    = 8;
  localparam int CTRL_ALU_SRC    = 7;
  localparam int CTRL_MEM_TO_REG = 6;
  localparam int CTRL_REG_WRITE  = 5;
  localparam int CTRL_MEM_READ   = 4;
  localparam int CTRL_MEM_WRITE  = 3;
  localparam int CTRL_BRANCH     = 2;
  localparam int CTRL_ALUOP_HI   = 1;
  localparam int CTRL_ALUOP_LO   = 0;

  typedef enum logic [1:0] {
    ALU_ADD   = 2'b00,  // address generation for lw/sw
    ALU_SUB   = 2'b01,  // compare for beq
    ALU_FUNCT = 2'b10,  // R-type, operation taken from funct field
    ALU_IMM   = 2'b11   // immediate-class operations
  } alu_op_e;

  typedef enum logic [5:0] {
    OPC_RTYPE = 6'b000000,
    OPC_LW    = 6'b100011,
    OPC_SW    = 6'b101011,
    OPC_BEQ   = 6'b000100,
    OPC_EXT0  = 6'b111111,
    OPC_EXT1  = 6'b111110
  } opcode_e;

endpackage

// File: rtl/load_use_detect.sv
// -----------------------------------------------------------------------------
// load_use_detect
// Combinational load-use hazard check between the instruction in EX and the
// instruction currently being decoded.
// Ports:
//   valid_ex_i    : EX holds a real instruction
//   mem_read_ex_i : the EX instruction is a load
//   rt_ex_i       : load destination register
//   id_valid_i    : ID holds a real instruction
//   rs_id_i/rt_id_i : source register fields of the ID instruction
//   hazard_o      : ID reads the register the EX load has not yet produced
// -----------------------------------------------------------------------------
module load_use_detect #(
  parameter int REG_AW = 5
) (
  input  logic              valid_ex_i,
  input  logic              mem_read_ex_i,
  input  logic [REG_AW-1:0] rt_ex_i,
  input  logic              id_valid_i,
  input  logic [REG_AW-1:0] rs_id_i,
  input  logic [REG_AW-1:0] rt_id_i,
  output logic              hazard_o
);

  // Register 0 is hard-wired, so a load targeting it never blocks anybody.
  assign hazard_o = valid_ex_i & mem_read_ex_i & (rt_ex_i != '0) & id_valid_i &
                    ((rs_id_i == rt_ex_i) | (rt_id_i == rt_ex_i));

endmodule

// File: rtl/id_ex_stage.sv
// -----------------------------------------------------------------------------
// id_ex_stage
// ID/EX pipeline register. Captures the sanitised decoder control word and the
// decode-stage operands, presenting them to EX one cycle later. Inserts a
// bubble on flush, on a load-use hazard, or when ID is empty, and counts stall
// cycles in a saturating counter.
// Ports:
//   clk, rst              : clock, synchronous active-high reset
//   id_valid_in           : ID holds a real instruction
//   control_in            : decoder control word
//   pc4_in, rd1_in, rd2_in, imm_in : decode-stage data
//   rs_in, rt_in, rd_in   : register fields
//   flush_in              : squash the ID instruction
//   control_ex .. rd_ex   : registered copies for EX, valid_ex marks real ones
//   stall_out             : hold PC and IF/ID this cycle (combinational)
//   stall_count           : saturating count of stall cycles since reset
// -----------------------------------------------------------------------------
module id_ex_stage
  import proc_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int CTRL_W = 10,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid_in,
  input  logic [CTRL_W-1:0] control_in,
  input  logic [DATA_W-1:0] pc4_in,
  input  logic [DATA_W-1:0] rd1_in,
  input  logic [DATA_W-1:0] rd2_in,
  input  logic [DATA_W-1:0] imm_in,
  input  logic [REG_AW-1:0] rs_in,
  input  logic [REG_AW-1:0] rt_in,
  input  logic [REG_AW-1:0] rd_in,
  input  logic              flush_in,
  output logic [CTRL_W-1:0] control_ex,
  output logic              valid_ex,
  output logic [DATA_W-1:0] pc4_ex,
  output logic [DATA_W-1:0] rd1_ex,
  output logic [DATA_W-1:0] rd2_ex,
  output logic [DATA_W-1:0] imm_ex,
  output logic [REG_AW-1:0] rs_ex,
  output logic [REG_AW-1:0] rt_ex,
  output logic [REG_AW-1:0] rd_ex,
  output logic              stall_out,
  output logic [CNT_W-1:0]  stall_count
);

  logic [CTRL_W-1:0] ctrl_q, ctrl_d, ctrl_san;
  logic              valid_q, valid_d;
  logic [DATA_W-1:0] pc4_q, pc4_d, rd1_q, rd1_d, rd2_q, rd2_d, imm_q, imm_d;
  logic [REG_AW-1:0] rs_q, rs_d, rt_q, rt_d, rd_q, rd_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              hazard;

  load_use_detect #(.REG_AW(REG_AW)) u_hazard (
    .valid_ex_i    (valid_q),
    .mem_read_ex_i (ctrl_q[CTRL_MEM_READ]),
    .rt_ex_i       (rt_q),
    .id_valid_i    (id_valid_in),
    .rs_id_i       (rs_in),
    .rt_id_i       (rt_in),
    .hazard_o      (hazard)
  );

  // A flushed instruction is discarded anyway, so holding the front end for it
  // would only waste a cycle.
  assign stall_out = hazard & ~flush_in;

  always_comb begin
    // Without a register write, reg_dst and mem_to_reg are decoder don't-cares;
    // clearing them keeps unknowns from ever reaching EX.
    ctrl_san = control_in;
    if (!control_in[CTRL_REG_WRITE]) begin
      ctrl_san[CTRL_REG_DST]    = 1'b0;
      ctrl_san[CTRL_MEM_TO_REG] = 1'b0;
    end
  end

  always_comb begin
    // NOTE: every next-state signal gets its bubble value first, so no path
    // leaves one unassigned and no latch is inferred.
    ctrl_d  = '0;
    valid_d = 1'b0;
    pc4_d   = '0;
    rd1_d   = '0;
    rd2_d   = '0;
    imm_d   = '0;
    rs_d    = '0;
    rt_d    = '0;
    rd_d    = '0;
    if (!flush_in && !hazard && id_valid_in) begin
      ctrl_d  = ctrl_san;
      valid_d = 1'b1;
      pc4_d   = pc4_in;
      rd1_d   = rd1_in;
      rd2_d   = rd2_in;
      imm_d   = imm_in;
      rs_d    = rs_in;
      rt_d    = rt_in;
      rd_d    = rd_in;
    end

    cnt_d = cnt_q;
    if (stall_out && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples its pre-edge inputs regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      ctrl_q  <= '0;
      valid_q <= 1'b0;
      pc4_q   <= '0;
      rd1_q   <= '0;
      rd2_q   <= '0;
      imm_q   <= '0;
      rs_q    <= '0;
      rt_q    <= '0;
      rd_q    <= '0;
      cnt_q   <= '0;
    end else begin
      ctrl_q  <= ctrl_d;
      valid_q <= valid_d;
      pc4_q   <= pc4_d;
      rd1_q   <= rd1_d;
      rd2_q   <= rd2_d;
      imm_q   <= imm_d;
      rs_q    <= rs_d;
      rt_q    <= rt_d;
      rd_q    <= rd_d;
      cnt_q   <= cnt_d;
    end
  end

  assign control_ex  = ctrl_q;
  assign valid_ex    = valid_q;
  assign pc4_ex      = pc4_q;
  assign rd1_ex      = rd1_q;
  assign rd2_ex      = rd2_q;
  assign imm_ex      = imm_q;
  assign rs_ex       = rs_q;
  assign rt_ex       = rt_q;
  assign rd_ex       = rd_q;
  assign stall_count = cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// -----------------------------------------------------------------------------
// tb_id_ex_stage
// Self-checking bench for id_ex_stage. A table of decode-stage vectors with
// expected EX contents drives the main checks; expected register contents are
// queued when each vector is driven and compared after the capturing edge.
// A second instance with a 4-bit stall counter exercises saturation.
// -----------------------------------------------------------------------------
module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid_in;
  logic [9:0]  control_in;
  logic [31:0] pc4_in, rd1_in, rd2_in, imm_in;
  logic [4:0]  rs_in, rt_in, rd_in;
  logic        flush_in;

  logic [9:0]  control_ex;
  logic        valid_ex;
  logic [31:0] pc4_ex, rd1_ex, rd2_ex, imm_ex;
  logic [4:0]  rs_ex, rt_ex, rd_ex;
  logic        stall_out;
  logic [15:0] stall_count;

  logic [9:0]  control_ex4;
  logic        valid_ex4;
  logic [31:0] pc4_ex4, rd1_ex4, rd2_ex4, imm_ex4;
  logic [4:0]  rs_ex4, rt_ex4, rd_ex4;
  logic        stall_out4;
  logic [3:0]  stall_count4;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  id_ex_stage dut (
    .clk(clk), .rst(rst), .id_valid_in(id_valid_in), .control_in(control_in),
    .pc4_in(pc4_in), .rd1_in(rd1_in), .rd2_in(rd2_in), .imm_in(imm_in),
    .rs_in(rs_in), .rt_in(rt_in), .rd_in(rd_in), .flush_in(flush_in),
    .control_ex(control_ex), .valid_ex(valid_ex), .pc4_ex(pc4_ex),
    .rd1_ex(rd1_ex), .rd2_ex(rd2_ex), .imm_ex(imm_ex), .rs_ex(rs_ex),
    .rt_ex(rt_ex), .rd_ex(rd_ex), .stall_out(stall_out),
    .stall_count(stall_count)
  );

  id_ex_stage #(.CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .id_valid_in(id_valid_in), .control_in(control_in),
    .pc4_in(pc4_in), .rd1_in(rd1_in), .rd2_in(rd2_in), .imm_in(imm_in),
    .rs_in(rs_in), .rt_in(rt_in), .rd_in(rd_in), .flush_in(flush_in),
    .control_ex(control_ex4), .valid_ex(valid_ex4), .pc4_ex(pc4_ex4),
    .rd1_ex(rd1_ex4), .rd2_ex(rd2_ex4), .imm_ex(imm_ex4), .rs_ex(rs_ex4),
    .rt_ex(rt_ex4), .rd_ex(rd_ex4), .stall_out(stall_out4),
    .stall_count(stall_count4)
  );

  typedef struct {
    logic        v;
    logic [9:0]  ctrl;
    logic [4:0]  rs, rt, rd;
    logic [31:0] pc4, rd1, rd2, imm;
    logic        flush;
    logic        exp_stall;
    logic [9:0]  exp_ctrl;
    logic        exp_valid;
    logic [15:0] exp_cnt;
  } vec_t;

  typedef struct {
    logic [9:0]  ctrl;
    logic        valid;
    logic [31:0] pc4, rd1, rd2, imm;
    logic [4:0]  rs, rt, rd;
    logic [15:0] cnt;
  } exp_t;

  exp_t sb[$];
  vec_t tbl[17];

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input int idx, input logic v, input logic [9:0] ctrl,
                              input logic [4:0] rs, input logic [4:0] rt,
                              input logic [4:0] rd, input logic flush,
                              input logic es, input logic [9:0] ec,
                              input logic ev, input logic [15:0] ecnt);
    vec_t t;
    t.v = v; t.ctrl = ctrl; t.rs = rs; t.rt = rt; t.rd = rd; t.flush = flush;
    t.rd1 = 32'h5 + (idx << 8);
    t.rd2 = 32'h7 + (idx << 8);
    t.imm = 32'hFFFF_FF00 | idx;
    t.pc4 = 32'h0040_0004 + (idx << 2);
    t.exp_stall = es; t.exp_ctrl = ec; t.exp_valid = ev; t.exp_cnt = ecnt;
    return t;
  endfunction

  function automatic logic [31:0] sat4(input logic [15:0] c);
    return (c > 16'd15) ? 32'd15 : {16'b0, c};
  endfunction

  task automatic cmp_regs(input exp_t e, input string tag);
    check({tag, " control_ex"}, 32'(control_ex), 32'(e.ctrl));
    check({tag, " valid_ex"},   32'(valid_ex),   32'(e.valid));
    check({tag, " pc4_ex"},     pc4_ex,          e.pc4);
    check({tag, " rd1_ex"},     rd1_ex,          e.rd1);
    check({tag, " rd2_ex"},     rd2_ex,          e.rd2);
    check({tag, " imm_ex"},     imm_ex,          e.imm);
    check({tag, " rs_ex"},      32'(rs_ex),      32'(e.rs));
    check({tag, " rt_ex"},      32'(rt_ex),      32'(e.rt));
    check({tag, " rd_ex"},      32'(rd_ex),      32'(e.rd));
    check({tag, " stall_count"}, 32'(stall_count), 32'(e.cnt));
    check({tag, " stall_count4"}, 32'(stall_count4), sat4(e.cnt));
  endtask

  // Drive one decode-stage vector at the falling edge, check the combinational
  // stall, then compare the captured EX contents after the next rising edge.
  task automatic apply(input vec_t t, input string tag);
    exp_t e, got;
    id_valid_in = t.v;   control_in = t.ctrl;
    rs_in = t.rs;        rt_in = t.rt;        rd_in = t.rd;
    pc4_in = t.pc4;      rd1_in = t.rd1;      rd2_in = t.rd2;
    imm_in = t.imm;      flush_in = t.flush;
    #1;
    check({tag, " stall_out"}, 32'(stall_out), 32'(t.exp_stall));
    e.ctrl  = t.exp_ctrl;
    e.valid = t.exp_valid;
    e.pc4   = t.exp_valid ? t.pc4 : 32'h0;
    e.rd1   = t.exp_valid ? t.rd1 : 32'h0;
    e.rd2   = t.exp_valid ? t.rd2 : 32'h0;
    e.imm   = t.exp_valid ? t.imm : 32'h0;
    e.rs    = t.exp_valid ? t.rs  : 5'h0;
    e.rt    = t.exp_valid ? t.rt  : 5'h0;
    e.rd    = t.exp_valid ? t.rd  : 5'h0;
    e.cnt   = t.exp_cnt;
    sb.push_back(e);
    @(posedge clk);
    #1;
    got = sb.pop_front();
    cmp_regs(got, tag);
    @(negedge clk);
  endtask

  task automatic drive_random();
    id_valid_in = 1'($urandom);
    control_in  = 10'($urandom);
    rs_in = 5'($urandom); rt_in = 5'($urandom); rd_in = 5'($urandom);
    pc4_in = $urandom; rd1_in = $urandom; rd2_in = $urandom; imm_in = $urandom;
    flush_in = 1'($urandom);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t  zero;
    logic [15:0] model_cnt;
    zero = '{ctrl: '0, valid: 1'b0, pc4: '0, rd1: '0, rd2: '0, imm: '0,
              rs: '0, rt: '0, rd: '0, cnt: '0};

    //        idx v  ctrl    rs  rt  rd fl  es exp_ctrl ev cnt
    tbl[0]  = mk(0,  1, 10'h122, 1,  2,  3, 0,  0, 10'h122, 1, 0); // R-type
    tbl[1]  = mk(1,  1, 10'h0F0, 1,  8,  0, 0,  0, 10'h0F0, 1, 0); // lw r8
    tbl[2]  = mk(2,  1, 10'h122, 8,  9, 10, 0,  1, 10'h000, 0, 1); // use r8: stall
    tbl[3]  = mk(3,  1, 10'h122, 8,  9, 10, 0,  0, 10'h122, 1, 1); // retried add
    tbl[4]  = mk(4,  1, 10'h1C8, 10, 8,  0, 0,  0, 10'h088, 1, 1); // sw, junk bits
    tbl[5]  = mk(5,  1, 10'h0F0, 2,  5,  0, 0,  0, 10'h0F0, 1, 1); // lw r5
    tbl[6]  = mk(6,  1, 10'h122, 5,  6, 11, 1,  0, 10'h000, 0, 1); // flush wins
    tbl[7]  = mk(7,  1, 10'h122, 5,  6, 11, 0,  0, 10'h122, 1, 1);
    tbl[8]  = mk(8,  1, 10'h0F0, 3,  0,  0, 0,  0, 10'h0F0, 1, 1); // lw r0
    tbl[9]  = mk(9,  1, 10'h122, 0,  0, 12, 0,  0, 10'h122, 1, 1); // r0: no stall
    tbl[10] = mk(10, 1, 10'h0F0, 3,  7,  0, 0,  0, 10'h0F0, 1, 1); // lw r7
    tbl[11] = mk(11, 1, 10'h122, 1,  7, 13, 0,  1, 10'h000, 0, 2); // rt match
    tbl[12] = mk(12, 0, 10'h122, 1,  7, 13, 0,  0, 10'h000, 0, 2); // ID empty
    tbl[13] = mk(13, 1, 10'h0F0, 3,  4,  0, 0,  0, 10'h0F0, 1, 2); // lw r4
    tbl[14] = mk(14, 0, 10'h122, 4,  4,  1, 0,  0, 10'h000, 0, 2); // invalid ID
    tbl[15] = mk(15, 1, 10'h122, 4,  2,  1, 0,  0, 10'h122, 1, 2);
    tbl[16] = mk(16, 1, 10'h145, 1,  2,  0, 0,  0, 10'h005, 1, 2); // beq, junk bits

    // Reset for two cycles with random inputs.
    rst = 1'b1;
    drive_random();
    @(negedge clk);
    for (int c = 0; c < 2; c++) begin
      drive_random();
      @(posedge clk);
      #1;
      cmp_regs(zero, $sformatf("reset%0d", c));
      check($sformatf("reset%0d stall_out", c), 32'(stall_out), 32'd0);
      @(negedge clk);
    end
    rst = 1'b0;

    for (int i = 0; i < 17; i++) begin
      apply(tbl[i], $sformatf("vec%0d", i));
    end
    model_cnt = 16'd2;

    // Store with unknown don't-care bits.
    id_valid_in = 1'b1; control_in = 10'b0x1x001000; flush_in = 1'b0;
    rs_in = 5'd3; rt_in = 5'd9; rd_in = 5'd0;
    @(posedge clk);
    #1;
    check("xsan control_ex", 32'(control_ex), 32'h088);
    check("xsan no_unknown",
          32'($isunknown({control_ex, valid_ex, pc4_ex, rd1_ex, rd2_ex, imm_ex,
                          rs_ex, rt_ex, rd_ex, stall_out, stall_count})), 32'd0);
    @(negedge clk);

    // Twenty load-use pairs: the 4-bit counter must stop at 15.
    for (int p = 0; p < 20; p++) begin
      apply(mk(p, 1, 10'h0F0, 1, 8, 0, 0, 0, 10'h0F0, 1, model_cnt),
            $sformatf("sat%0d lw", p));
      model_cnt++;
      apply(mk(p, 1, 10'h122, 8, 9, 10, 0, 1, 10'h000, 0, model_cnt),
            $sformatf("sat%0d stall", p));
      apply(mk(p, 1, 10'h122, 8, 9, 10, 0, 0, 10'h122, 1, model_cnt),
            $sformatf("sat%0d add", p));
    end

    // Reset asserted while a load-use stall is in progress.
    apply(mk(30, 1, 10'h0F0, 1, 8, 0, 0, 0, 10'h0F0, 1, model_cnt), "rstmid lw");
    id_valid_in = 1'b1; control_in = 10'h122; rs_in = 5'd8; rt_in = 5'd9;
    #1;
    check("rstmid stall_before", 32'(stall_out), 32'd1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    cmp_regs(zero, "rstmid");
    check("rstmid stall_after", 32'(stall_out), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    check("scoreboard drained", 32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
